// File: rtl/task_sequencer_if.sv
// Control/task-bus bundle between the PC task block, the controller and the sequencer.
interface task_sequencer_if #(
  parameter int PC_W    = 4,
  parameter int TASKS_W = 16,
  parameter int COND_W  = 4,
  parameter int CSEL_W  = 3,
  parameter int REP_W   = 4
);
  localparam int WORD_W = 1 + REP_W + CSEL_W + TASKS_W;

  logic [PC_W-1:0]    pc_in;
  logic               start;
  logic               abort;
  logic [COND_W-1:0]  cond;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [WORD_W-1:0]  prog_data;
  logic [TASKS_W-1:0] tasks;
  logic               busy;
  logic               done;

  // Controller / PC block side.
  modport master (
    output pc_in, start, abort, cond, prog_we, prog_addr, prog_data,
    input  tasks, busy, done
  );

  // Sequencer side.
  modport slave (
    input  pc_in, start, abort, cond, prog_we, prog_addr, prog_data,
    output tasks, busy, done
  );
endinterface

// File: rtl/task_sequencer.sv
// Microprogram sequencer: reads the word at the current PC, waits on a selected
// condition, repeats words by holding the PC, and ends programs with a restart.
module task_sequencer #(
  parameter int                 PC_W         = 4,
  parameter int                 TASKS_W      = 16,
  parameter int                 COND_W       = 4,
  parameter int                 CSEL_W       = 3,
  parameter int                 REP_W        = 4,
  parameter logic [TASKS_W-1:0] TASK_HOLD    = 16'h4000,
  parameter logic [TASKS_W-1:0] TASK_RESTART = 16'h8000
) (
  input  logic            clk,
  input  logic            reset,
  task_sequencer_if.slave bus
);
  localparam int WORD_W = 1 + REP_W + CSEL_W + TASKS_W;
  localparam int DEPTH  = 2 ** PC_W;
  localparam int NSEL   = 2 ** CSEL_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [REP_W-1:0]   r_rep_cnt;
  logic               r_rep_act;
  logic               r_done;
  logic [WORD_W-1:0]  r_mem [0:DEPTH-1];

  logic [WORD_W-1:0]  w_word;
  logic               w_end;
  logic [REP_W-1:0]   w_rep;
  logic [CSEL_W-1:0]  w_csel;
  logic [TASKS_W-1:0] w_body;
  logic [NSEL-1:0]    w_cond_ok;
  logic               w_wait;
  logic               w_last;
  logic [TASKS_W-1:0] w_tasks;

  // Word fields: {END, REP, CSEL, TASKS}. Read is asynchronous because the
  // task bus must follow the PC in the same cycle.
  assign w_word = r_mem[bus.pc_in];
  assign w_end  = w_word[WORD_W-1];
  assign w_rep  = w_word[TASKS_W+CSEL_W +: REP_W];
  assign w_csel = w_word[TASKS_W +: CSEL_W];
  // HOLD and RESTART are reserved for the sequencer itself.
  assign w_body = w_word[TASKS_W-1:0] & ~(TASK_HOLD | TASK_RESTART);

  // Condition select table: CSEL=k (1..COND_W) tests cond[k-1]; other codes never wait.
  for (genvar gi = 0; gi < NSEL; gi++) begin : g_cond
    if (gi >= 1 && gi <= COND_W) begin : g_sel
      assign w_cond_ok[gi] = bus.cond[gi-1];
    end else begin : g_free
      assign w_cond_ok[gi] = 1'b1;
    end
  end

  // The condition is only checked before the first run of a word.
  assign w_wait = !r_rep_act && !w_cond_ok[w_csel];
  // Final run of a word: either no repeats at all, or the repeat count has drained.
  assign w_last = r_rep_act ? (r_rep_cnt == '0) : (w_rep == '0);

  // Task bus: hold in IDLE, restart on abort, hold while waiting, else the word's tasks.
  always_comb begin
    w_tasks = TASK_HOLD;
    if (r_state == S_RUN) begin
      if (bus.abort) begin
        w_tasks = TASK_RESTART;
      end else if (w_wait) begin
        w_tasks = TASK_HOLD;
      end else begin
        w_tasks = w_body;
        if (!w_last) begin
          w_tasks = w_tasks | TASK_HOLD;
        end else if (w_end) begin
          w_tasks = w_tasks | TASK_RESTART;
        end
      end
    end
  end

  assign bus.tasks = w_tasks;
  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = r_done;

  // Program memory write port; locked out while a program is running.
  always_ff @(posedge clk) begin
    if (bus.prog_we && r_state != S_RUN) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Sequencer state, repeat counter and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rep_cnt <= '0;
      r_rep_act <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (bus.start && !bus.abort) begin
          r_state <= S_RUN;
        end
      end else begin
        if (bus.abort) begin
          r_state   <= S_IDLE;
          r_rep_act <= 1'b0;
          r_rep_cnt <= '0;
        end else if (!w_wait) begin
          if (!w_last) begin
            if (r_rep_act) begin
              r_rep_cnt <= r_rep_cnt - 1'b1;
            end else begin
              r_rep_cnt <= w_rep - 1'b1;
              r_rep_act <= 1'b1;
            end
          end else begin
            r_rep_act <= 1'b0;
            if (w_end) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule
